// File: rtl/sad_pkg.sv
// sad_pkg: shared FSM state type and width helpers for the SAD match engine
package sad_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SEARCH, RESULT} state_t;
  function automatic int min1_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
  function automatic int sad_width(input int pix_w, input int tpl_w, input int tpl_h);
    return pix_w + $clog2(tpl_w * tpl_h);
  endfunction
endpackage

// File: rtl/sad_window_pe.sv
// sad_window_pe: combinational SAD of one template row against one image window
module sad_window_pe #(
  parameter int TPL_W = 8,
  parameter int PIX_W = 8,
  parameter int OUT_W = 11
) (
  input  logic [TPL_W*PIX_W-1:0] win,
  input  logic [TPL_W*PIX_W-1:0] tpl,
  output logic [OUT_W-1:0]       sad
);
  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction
  always_comb begin
    sad = '0;
    for (int k = 0; k < TPL_W; k++)
      sad = sad + OUT_W'(absdiff(win[k*PIX_W +: PIX_W], tpl[k*PIX_W +: PIX_W]));
  end
endmodule

// File: rtl/sad_match_engine.sv
// sad_match_engine: 2-D SAD accumulation over all placements in a strip, then
// a sequential minimum search returning best column, SAD and threshold match
module sad_match_engine import sad_pkg::*; #(
  parameter int NUM_COLS = 64,
  parameter int PIX_W    = 8,
  parameter int TPL_W    = 8,
  parameter int TPL_H    = 8,
  parameter int NUM_POS  = NUM_COLS - TPL_W + 1,
  parameter int SAD_W    = sad_width(PIX_W, TPL_W, TPL_H),
  parameter int COL_W    = min1_clog2(NUM_POS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SAD_W-1:0]          threshold,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [NUM_COLS*PIX_W-1:0] row_pix,
  input  logic [TPL_W*PIX_W-1:0]    tpl_pix,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [COL_W-1:0]          res_col,
  output logic [SAD_W-1:0]          res_sad,
  output logic                      res_match,
  output logic                      busy
);
  localparam int RC_W = min1_clog2(TPL_H);
  state_t             state;
  logic [RC_W-1:0]    row_cnt;
  logic [COL_W-1:0]   pos, best_col, nxt_col;
  logic [SAD_W-1:0]   best, thr, cur, nxt_best;
  logic [SAD_W-1:0]   acc     [NUM_POS];
  logic [SAD_W-1:0]   row_sad [NUM_POS];
  logic               lt, last_pos, last_row;
  assign row_ready = state == ACCUM;
  assign res_valid = state == RESULT;
  assign busy      = state != IDLE;
  for (genvar p = 0; p < NUM_POS; p++) begin : g_pe
    sad_window_pe #(.TPL_W(TPL_W), .PIX_W(PIX_W), .OUT_W(SAD_W)) u_pe (
      .win(row_pix[p*PIX_W +: TPL_W*PIX_W]),
      .tpl(tpl_pix),
      .sad(row_sad[p])
    );
  end
  // strict less-than keeps the lowest column on ties
  always_comb begin
    cur      = acc[pos];
    lt       = cur < best;
    nxt_best = lt ? cur : best;
    nxt_col  = lt ? pos : best_col;
    last_pos = pos == COL_W'(NUM_POS - 1);
    last_row = row_cnt == RC_W'(TPL_H - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      pos       <= '0;
      best      <= '0;
      best_col  <= '0;
      thr       <= '0;
      res_col   <= '0;
      res_sad   <= '0;
      res_match <= 1'b0;
      for (int p = 0; p < NUM_POS; p++) acc[p] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= ACCUM;
          thr     <= threshold;
          row_cnt <= '0;
          for (int p = 0; p < NUM_POS; p++) acc[p] <= '0;
        end
        ACCUM: if (row_valid) begin
          for (int p = 0; p < NUM_POS; p++) acc[p] <= acc[p] + row_sad[p];
          row_cnt <= row_cnt + 1'b1;
          if (last_row) begin
            state    <= SEARCH;
            pos      <= '0;
            best     <= '1;
            best_col <= '0;
          end
        end
        SEARCH: begin
          best     <= nxt_best;
          best_col <= nxt_col;
          pos      <= pos + 1'b1;
          if (last_pos) begin
            state     <= RESULT;
            res_col   <= nxt_col;
            res_sad   <= nxt_best;
            res_match <= nxt_best <= thr;
          end
        end
        RESULT: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sad_match_engine.sv
// tb_sad_match_engine: table-driven directed checks of the SAD match engine
module tb_sad_match_engine;
  localparam int NC = 16, TW = 4, TH = 2, PW = 8, SW = 11, CW = 4;
  logic clk = 1'b0, rst, start, row_valid, res_ready;
  logic row_ready, res_valid, res_match, busy;
  logic [SW-1:0] threshold, res_sad;
  logic [CW-1:0] res_col;
  logic [NC*PW-1:0] row_pix;
  logic [TW*PW-1:0] tpl_pix;
  int total = 0, bad = 0;
  typedef struct {
    string name;
    logic [NC*PW-1:0] r0, r1;
    logic [TW*PW-1:0] tpl;
    logic [SW-1:0] thr;
    int col, sad;
    logic m;
  } vec_t;
  vec_t v[6];
  logic [NC*PW-1:0] r;

  sad_match_engine #(.NUM_COLS(NC), .PIX_W(PW), .TPL_W(TW), .TPL_H(TH)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .row_valid(row_valid), .row_ready(row_ready), .row_pix(row_pix), .tpl_pix(tpl_pix),
    .res_valid(res_valid), .res_ready(res_ready), .res_col(res_col), .res_sad(res_sad),
    .res_match(res_match), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the result is consumed.
  task automatic run(input vec_t x, input int gap, input int hold);
    int lat;
    start = 1'b1;
    threshold = x.thr;
    @(negedge clk);
    start = 1'b0;
    chk({x.name, " busy"}, busy, 1);
    chk({x.name, " row_ready"}, row_ready, 1);
    for (int k = 0; k < TH; k++) begin
      repeat (gap) begin
        row_valid = 1'b0;
        row_pix = '1;
        @(negedge clk);
      end
      row_valid = 1'b1;
      row_pix = (k == 0) ? x.r0 : x.r1;
      tpl_pix = x.tpl;
      @(negedge clk);
    end
    row_valid = 1'b0;
    chk({x.name, " row_ready_off"}, row_ready, 0);
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({x.name, " latency"}, lat, 14);
    chk({x.name, " col"}, res_col, x.col);
    chk({x.name, " sad"}, res_sad, x.sad);
    chk({x.name, " match"}, res_match, x.m);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      row_valid = 1'b1;
      row_pix = {4{$urandom()}};
      @(negedge clk);
      chk("hold valid", res_valid, 1);
      chk("hold row_ready", row_ready, 0);
      chk("hold col", res_col, x.col);
      chk("hold sad", res_sad, x.sad);
      chk("hold match", res_match, x.m);
    end
    start = 1'b0;
    row_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({x.name, " valid_off"}, res_valid, 0);
    chk({x.name, " busy_off"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_valid = 1'b0; res_ready = 1'b0;
    threshold = '0; row_pix = '0; tpl_pix = '0;
    r = '0;
    for (int c = 5; c <= 8; c++) r[c*PW +: PW] = 8'd100;
    v[0] = '{"exact", r, r, {4{8'd100}}, 11'd0, 5, 0, 1'b1};
    v[1] = '{"tie", {16{8'd37}}, {16{8'd37}}, {4{8'd37}}, 11'd0, 0, 0, 1'b1};
    v[2] = '{"thr79", 128'd0, 128'd0, {4{8'd10}}, 11'd79, 0, 80, 1'b0};
    v[3] = '{"thr80", 128'd0, 128'd0, {4{8'd10}}, 11'd80, 0, 80, 1'b1};
    v[4] = '{"max", 128'd0, 128'd0, {4{8'd255}}, 11'd0, 0, 2040, 1'b0};
    for (int c = 0; c < NC; c++) r[c*PW +: PW] = 8'(c * 10);
    v[5] = '{"ramp", r, 128'd0, {8'd82, 8'd72, 8'd62, 8'd52}, 11'd276, 5, 276, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst row_ready", row_ready, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst col", res_col, 0);
    chk("rst sad", res_sad, 0);
    chk("rst match", res_match, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run(v[i], (i % 2) * 3, 0);
    run(v[0], 0, 5);
    start = 1'b1;
    threshold = '0;
    @(negedge clk);
    start = 1'b0;
    row_valid = 1'b1;
    row_pix = '1;
    tpl_pix = '0;
    @(negedge clk);
    row_valid = 1'b0;
    chk("abort busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort row_ready", row_ready, 0);
    chk("abort res_valid", res_valid, 0);
    chk("abort busy_off", busy, 0);
    chk("abort col", res_col, 0);
    chk("abort sad", res_sad, 0);
    chk("abort match", res_match, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(v[0], 0, 0);
    run(v[4], 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
